nest_ctrl: RTL and testbench

Interrupt nesting controller that drives the `stack` priority stack. It tracks the currently running priority level. On a preempting interrupt it pushes that level and raises it to the new interrupt's priority. On a return it pops the saved level back. It sits between the interrupt arbiter/core retire logic and one `stack` instance, and is the only agent that asserts that stack's push/pop.

---
 rtl/nest_ctrl_if.sv | 35 +++
 rtl/nest_ctrl.sv | 141 ++++++++++++++
 tb/tb_nest_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nest_ctrl_if.sv
// Handshake and stack-side signal bundle for nest_ctrl.
// master = the nesting controller, slave = arbiter/retire logic plus the attached stack.
interface nest_ctrl_if #(
  parameter int unsigned PrioWidth  = 3,
  parameter int unsigned StackDepth = 8,
  parameter int unsigned DataWidth  = 8
);
  localparam int unsigned DepthWidth = $clog2(StackDepth);

  logic                  irq_valid;
  logic [PrioWidth-1:0]  irq_prio;
  logic                  irq_ack;
  logic                  ret_req;
  logic                  ret_done;
  logic [PrioWidth-1:0]  cur_prio;
  logic [DepthWidth-1:0] depth;
  logic                  stack_push;
  logic                  stack_pop;
  logic [DataWidth-1:0]  stack_wdata;
  logic [DataWidth-1:0]  stack_rdata;
  logic                  overflow;
  logic                  underflow;

  modport master (
    input  irq_valid, irq_prio, ret_req, stack_rdata,
    output irq_ack, ret_done, cur_prio, depth, stack_push, stack_pop, stack_wdata,
    output overflow, underflow
  );

  modport slave (
    output irq_valid, irq_prio, ret_req, stack_rdata,
    input  irq_ack, ret_done, cur_prio, depth, stack_push, stack_pop, stack_wdata,
    input  overflow, underflow
  );
endinterface

// File: rtl/nest_ctrl.sv
// Interrupt nesting controller: saves/restores the running priority on an external stack.
// Optional tail-chaining of a return into a higher pending irq: define NEST_TAIL_CHAIN_EN.
module nest_ctrl #(
  parameter int unsigned PrioWidth  = 3,
  parameter int unsigned StackDepth = 8,
  parameter int unsigned DataWidth  = 8
) (
  input logic         clk,
  input logic         reset,
  nest_ctrl_if.master bus
);
  localparam int unsigned DepthWidth = $clog2(StackDepth);
  localparam logic [DepthWidth-1:0] DepthFull = DepthWidth'(StackDepth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StTake,
    StPop,
    StRet
`ifdef NEST_TAIL_CHAIN_EN
    , StTail
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [PrioWidth-1:0]  cur_q, cur_d;
  logic [PrioWidth-1:0]  prio_q, prio_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  push, pop, ack, done;
  logic                  irq_qual;
  logic [PrioWidth-1:0]  top_prio;
  logic                  unused_rdata;

  assign top_prio     = bus.stack_rdata[PrioWidth-1:0];
  assign unused_rdata = ^bus.stack_rdata;
  assign irq_qual     = bus.irq_valid && (bus.irq_prio > cur_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prio_d  = prio_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    ack     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A return always takes precedence over a new request.
        if (bus.ret_req) begin
          if (depth_q != '0) begin
`ifdef NEST_TAIL_CHAIN_EN
            if (bus.irq_valid && (bus.irq_prio > top_prio)) begin
              prio_d  = bus.irq_prio;
              state_d = StTail;
            end else begin
              state_d = StPop;
            end
`else
            state_d = StPop;
`endif
          end else begin
            unf_d   = 1'b1;
            state_d = StRet;
          end
        end else if (irq_qual) begin
          if (depth_q != DepthFull) begin
            prio_d  = bus.irq_prio;
            state_d = StPush;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StPush: begin
        push    = 1'b1;
        depth_d = depth_q + DepthWidth'(1);
        state_d = StTake;
      end
      StTake: begin
        ack     = 1'b1;
        cur_d   = prio_q;
        state_d = StIdle;
      end
      StPop: begin
        // Top of stack is read combinationally before the stack index moves.
        pop     = 1'b1;
        cur_d   = top_prio;
        depth_d = depth_q - DepthWidth'(1);
        state_d = StRet;
      end
      StRet: begin
        done    = 1'b1;
        state_d = StIdle;
      end
`ifdef NEST_TAIL_CHAIN_EN
      StTail: begin
        ack     = 1'b1;
        done    = 1'b1;
        cur_d   = prio_q;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      prio_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prio_q  <= prio_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.irq_ack     = ack;
  assign bus.ret_done    = done;
  assign bus.stack_push  = push;
  assign bus.stack_pop   = pop;
  assign bus.stack_wdata = DataWidth'(cur_q);
  assign bus.cur_prio    = cur_q;
  assign bus.depth       = depth_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_nest_ctrl.sv
// Self-checking bench for nest_ctrl: behavioural stack + transaction-level reference model.
module tb_nest_ctrl;
  localparam int PW = 4;
  localparam int SD = 8;
  localparam int DW = 8;

  logic clk;
  logic reset;

  nest_ctrl_if #(.PrioWidth(PW), .StackDepth(SD), .DataWidth(DW)) bus ();

  nest_ctrl #(.PrioWidth(PW), .StackDepth(SD), .DataWidth(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural stack attached to the controller.
  logic [DW-1:0] smem [SD];
  int            sp = 0;
  logic [DW-1:0] push_log [$];
  int            pop_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
    end else if (bus.stack_push) begin
      if (sp < SD) smem[sp] <= bus.stack_wdata;
      sp <= sp + 1;
      push_log.push_back(bus.stack_wdata);
    end else if (bus.stack_pop) begin
      if (sp > 0) sp <= sp - 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  assign bus.stack_rdata = (sp > 0 && sp <= SD) ? smem[sp-1] : '0;

  // Reference model: on each decision, schedule the per-cycle outputs of the whole transaction.
  typedef struct {
    bit push;
    bit pop;
    bit ack;
    bit done;
    int wdata;
    int cur;
    int depth;
  } rec_t;

  function automatic rec_t mk(bit push, bit pop, bit ack, bit done, int wdata, int cur,
                              int depth);
    rec_t r;
    r.push = push; r.pop = pop; r.ack = ack; r.done = done;
    r.wdata = wdata; r.cur = cur; r.depth = depth;
    return r;
  endfunction

  rec_t plan [$];
  int   saved [$];
  int   m_cur = 0, m_depth = 0;
  bit   m_ovf = 0, m_unf = 0;
  bit   started = 0;

  always @(posedge clk) begin
    if (reset) begin
      plan.delete();
      saved.delete();
      m_cur = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
    end else if (plan.size() > 0) begin
      void'(plan.pop_front());
    end else if (bus.ret_req) begin
      if (m_depth > 0) begin
`ifdef NEST_TAIL_CHAIN_EN
        if (bus.irq_valid && int'(bus.irq_prio) > saved[$]) begin
          plan.push_back(mk(0, 0, 1, 1, 0, m_cur, m_depth));
          m_cur = int'(bus.irq_prio);
        end else begin
`endif
          plan.push_back(mk(0, 1, 0, 0, 0, m_cur, m_depth));
          m_cur = saved.pop_back();
          m_depth--;
          plan.push_back(mk(0, 0, 0, 1, 0, m_cur, m_depth));
`ifdef NEST_TAIL_CHAIN_EN
        end
`endif
      end else begin
        plan.push_back(mk(0, 0, 0, 1, 0, m_cur, m_depth));
        m_unf = 1;
      end
    end else if (bus.irq_valid && int'(bus.irq_prio) > m_cur) begin
      if (m_depth < SD - 1) begin
        plan.push_back(mk(1, 0, 0, 0, m_cur, m_cur, m_depth));
        saved.push_back(m_cur);
        m_depth++;
        plan.push_back(mk(0, 0, 1, 0, 0, m_cur, m_depth));
        m_cur = int'(bus.irq_prio);
      end else begin
        m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    rec_t e;
    if (started) begin
      e = (plan.size() > 0) ? plan[0] : mk(0, 0, 0, 0, 0, m_cur, m_depth);
      check("cur_prio", bus.cur_prio, e.cur);
      check("depth", bus.depth, e.depth);
      check("stack_push", bus.stack_push, e.push);
      check("stack_pop", bus.stack_pop, e.pop);
      check("irq_ack", bus.irq_ack, e.ack);
      check("ret_done", bus.ret_done, e.done);
      check("overflow", bus.overflow, m_ovf);
      check("underflow", bus.underflow, m_unf);
      if (e.push) check("stack_wdata", bus.stack_wdata, e.wdata);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.irq_valid = 1'b0;
    bus.ret_req   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge while the controller is idle; returns at the ack negedge or budget end.
  task automatic do_irq(input int prio, input bit exp_ack);
    bit got = 0;
    bus.irq_valid = 1'b1;
    bus.irq_prio  = PW'(prio);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus.irq_ack;
    end
    bus.irq_valid = 1'b0;
    check($sformatf("irq_p%0d_acked", prio), got, exp_ack);
  endtask

  task automatic do_ret();
    bit got = 0;
    bus.ret_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus.ret_done;
    end
    bus.ret_req = 1'b0;
    check("ret_done_seen", got, 1);
  endtask

  task automatic do_both(input int prio, output bit same_cycle);
    bit got_a = 0, got_r = 0;
    same_cycle = 0;
    bus.irq_valid = 1'b1;
    bus.irq_prio  = PW'(prio);
    bus.ret_req   = 1'b1;
    for (int i = 0; i < 16 && !(got_a && got_r); i++) begin
      @(negedge clk);
      if (bus.irq_ack && bus.ret_done) same_cycle = 1;
      if (bus.ret_done) begin got_r = 1; bus.ret_req = 1'b0; end
      if (bus.irq_ack) begin got_a = 1; bus.irq_valid = 1'b0; end
    end
    bus.irq_valid = 1'b0;
    bus.ret_req   = 1'b0;
    check("both_ack_seen", got_a, 1);
    check("both_done_seen", got_r, 1);
  endtask

  initial begin
    bit same;
    int pops0;
    bit seen_push;
    bus.irq_prio = '0;
    do_reset();
    started = 1;

    // Reset then idle
    repeat (5) @(negedge clk);
    check("rst_cur", bus.cur_prio, 0);
    check("rst_depth", bus.depth, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_unf", bus.underflow, 0);

    // Single irq and return
    push_log.delete();
    do_irq(3, 1);
    @(negedge clk);
    check("single_cur", bus.cur_prio, 3);
    check("single_depth", bus.depth, 1);
    check("single_push_n", push_log.size(), 1);
    if (push_log.size() >= 1) check("single_wdata", push_log[0], 0);
    do_ret();
    check("single_ret_cur", bus.cur_prio, 0);
    check("single_ret_depth", bus.depth, 0);

    // Nesting 2,5,7 with a non-qualifying 4 at level 5
    push_log.delete();
    do_irq(2, 1);
    do_irq(5, 1);
    do_irq(4, 0);
    do_irq(7, 1);
    @(negedge clk);
    check("nest_cur7", bus.cur_prio, 7);
    check("nest_push_n", push_log.size(), 3);
    if (push_log.size() == 3) begin
      check("nest_w0", push_log[0], 0);
      check("nest_w1", push_log[1], 2);
      check("nest_w2", push_log[2], 5);
    end
    do_ret(); check("unnest_cur5", bus.cur_prio, 5);
    do_ret(); check("unnest_cur2", bus.cur_prio, 2);
    do_ret(); check("unnest_cur0", bus.cur_prio, 0);

    // Overflow: seven nested levels then an eighth qualifying irq
    for (int p = 1; p <= 7; p++) do_irq(p, 1);
    do_irq(8, 0);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_depth", bus.depth, 7);
    check("ovf_cur", bus.cur_prio, 7);
    do_reset();
    @(negedge clk);
    check("ovf_cleared", bus.overflow, 0);

    // Underflow: return at depth 0
    pops0 = pop_cnt;
    do_ret();
    @(negedge clk);
    check("unf_flag", bus.underflow, 1);
    check("unf_no_pop", pop_cnt - pops0, 0);
    check("unf_cur", bus.cur_prio, 0);

    // Return and higher irq together at level 2 over saved 0
    do_irq(2, 1);
    push_log.delete();
    do_both(4, same);
    @(negedge clk);
    check("both_cur", bus.cur_prio, 4);
    check("both_depth", bus.depth, 1);
`ifdef NEST_TAIL_CHAIN_EN
    check("both_same_cycle", same, 1);
    check("both_push_n", push_log.size(), 0);
`else
    check("both_same_cycle", same, 0);
    check("both_push_n", push_log.size(), 1);
    if (push_log.size() == 1) check("both_wdata", push_log[0], 0);
`endif

    // Reset asserted during the push cycle
    do_reset();
    @(negedge clk);
    seen_push = 0;
    bus.irq_valid = 1'b1;
    bus.irq_prio  = PW'(3);
    for (int i = 0; i < 6 && !seen_push; i++) begin
      @(negedge clk);
      seen_push = bus.stack_push;
    end
    check("rp_push_seen", seen_push, 1);
    reset = 1'b1;
    bus.irq_valid = 1'b0;
    @(negedge clk);
    check("rp_no_ack", bus.irq_ack, 0);
    check("rp_depth", bus.depth, 0);
    check("rp_cur", bus.cur_prio, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rp_idle_depth", bus.depth, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
